wreg_hazard_pipe: RTL and testbench

- Parametrised successor to the single-cycle write-register select, for the pipelined CPU.
- Selects each decoded instruction's destination register (rt / rd / link / none) in D.
- Carries destination and Tnew down the E/M/W pipeline registers.
- From the in-flight destinations, produces per-source forwarding selects and a D-stage stall request for the hazard unit.

---
 rtl/wreg_hazard_pipe.sv | 143 ++++++++++++++
 tb/tb_wreg_hazard_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wreg_hazard_pipe.sv
// Destination select for D, E/M/W destination + Tnew tracking, and the
// forwarding/stall decisions the hazard unit derives from them.
module wreg_hazard_pipe #(
   parameter int                REG_AW   = 5,
   parameter logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}},
   parameter int                TNEW_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush_e,
   input  logic              d_valid,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [REG_AW-1:0] d_rd,
   input  logic [1:0]        d_sel,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic [REG_AW-1:0] q_rs,
   input  logic [REG_AW-1:0] q_rt,
   input  logic [TNEW_W-1:0] tuse_rs,
   input  logic [TNEW_W-1:0] tuse_rt,
   output logic [REG_AW-1:0] d_dst,
   output logic [REG_AW-1:0] e_dst,
   output logic [REG_AW-1:0] m_dst,
   output logic [REG_AW-1:0] w_dst,
   output logic [TNEW_W-1:0] e_tnew,
   output logic [TNEW_W-1:0] m_tnew,
   output logic [1:0]        fwd_rs,
   output logic [1:0]        fwd_rt,
   output logic              stall_req
);

   localparam logic [1:0] SEL_RT   = 2'b00;
   localparam logic [1:0] SEL_RD   = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_E  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b11;

   logic [REG_AW-1:0] w_d_dst;
   logic              w_e_bubble;
   logic [2:0]        w_hz_rs;
   logic [2:0]        w_hz_rt;

   logic [REG_AW-1:0] r_e_dst;
   logic [REG_AW-1:0] r_m_dst;
   logic [REG_AW-1:0] r_w_dst;
   logic [TNEW_W-1:0] r_e_tnew;
   logic [TNEW_W-1:0] r_m_tnew;

   function automatic logic [TNEW_W-1:0] sat_dec(
      input logic [TNEW_W-1:0] x
   );
      return (x == '0) ? '0 : x - 1'b1;
   endfunction

   // Returns {stall, fwd[1:0]} for one source; youngest match decides fwd.
   function automatic logic [2:0] hazard(
      input logic [REG_AW-1:0] q,
      input logic [TNEW_W-1:0] tuse,
      input logic [REG_AW-1:0] ed,
      input logic [TNEW_W-1:0] et,
      input logic [REG_AW-1:0] md,
      input logic [TNEW_W-1:0] mt,
      input logic [REG_AW-1:0] wd
   );
      logic       me;
      logic       mm;
      logic       mw;
      logic       stl;
      logic [1:0] fwd;
      me  = (q != '0) && (q == ed);
      mm  = (q != '0) && (q == md);
      mw  = (q != '0) && (q == wd);
      stl = (me && (et > tuse)) || (mm && (mt > tuse));
      fwd = FWD_RF;
      if (me) begin
         fwd = (et == '0) ? FWD_E : FWD_RF;
      end else if (mm) begin
         fwd = (mt == '0) ? FWD_M : FWD_RF;
      end else if (mw) begin
         fwd = FWD_W;
      end
      return {stl, fwd};
   endfunction

   always_comb begin
      w_d_dst = '0;
      unique case (d_sel)
         SEL_RT:   w_d_dst = d_rt;
         SEL_RD:   w_d_dst = d_rd;
         SEL_LINK: w_d_dst = LINK_REG;
         SEL_NONE: w_d_dst = '0;
         default:  w_d_dst = '0;
      endcase
      if (!d_valid) begin
         w_d_dst = '0;
      end
   end

   assign w_e_bubble = stall | flush_e | ~d_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_e_dst  <= '0;
         r_e_tnew <= '0;
         r_m_dst  <= '0;
         r_m_tnew <= '0;
         r_w_dst  <= '0;
      end else begin
         if (w_e_bubble) begin
            r_e_dst  <= '0;
            r_e_tnew <= '0;
         end else begin
            r_e_dst  <= w_d_dst;
            r_e_tnew <= d_tnew;
         end
         r_m_dst  <= r_e_dst;
         r_m_tnew <= sat_dec(r_e_tnew);
         r_w_dst  <= r_m_dst;
      end
   end

   always_comb begin
      w_hz_rs = hazard(q_rs, tuse_rs, r_e_dst, r_e_tnew,
                       r_m_dst, r_m_tnew, r_w_dst);
      w_hz_rt = hazard(q_rt, tuse_rt, r_e_dst, r_e_tnew,
                       r_m_dst, r_m_tnew, r_w_dst);
   end

   assign d_dst     = w_d_dst;
   assign e_dst     = r_e_dst;
   assign m_dst     = r_m_dst;
   assign w_dst     = r_w_dst;
   assign e_tnew    = r_e_tnew;
   assign m_tnew    = r_m_tnew;
   assign fwd_rs    = w_hz_rs[1:0];
   assign fwd_rt    = w_hz_rt[1:0];
   assign stall_req = w_hz_rs[2] | w_hz_rt[2];

endmodule

// File: tb/tb_wreg_hazard_pipe.sv
// Scoreboard bench for wreg_hazard_pipe: stimulus queues expected
// output snapshots, a monitor compares them at the sampling point.
module tb_wreg_hazard_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall;
   logic       flush_e;
   logic       d_valid;
   logic [4:0] d_rt;
   logic [4:0] d_rd;
   logic [1:0] d_sel;
   logic [1:0] d_tnew;
   logic [4:0] q_rs;
   logic [4:0] q_rt;
   logic [1:0] tuse_rs;
   logic [1:0] tuse_rt;
   logic [4:0] d_dst;
   logic [4:0] e_dst;
   logic [4:0] m_dst;
   logic [4:0] w_dst;
   logic [1:0] e_tnew;
   logic [1:0] m_tnew;
   logic [1:0] fwd_rs;
   logic [1:0] fwd_rt;
   logic       stall_req;

   wreg_hazard_pipe dut (
      .clk(clk), .reset(reset), .stall(stall), .flush_e(flush_e),
      .d_valid(d_valid), .d_rt(d_rt), .d_rd(d_rd), .d_sel(d_sel),
      .d_tnew(d_tnew), .q_rs(q_rs), .q_rt(q_rt),
      .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .d_dst(d_dst),
      .e_dst(e_dst), .m_dst(m_dst), .w_dst(w_dst),
      .e_tnew(e_tnew), .m_tnew(m_tnew), .fwd_rs(fwd_rs),
      .fwd_rt(fwd_rt), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   // -1 in a field means that field is not checked.
   typedef struct {
      string nm;
      int    dd;
      int    ed;
      int    md;
      int    wd;
      int    et;
      int    mt;
      int    fr;
      int    ft;
      int    sr;
   } exp_t;

   exp_t q_exp[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   event mon_now;

   task automatic ex(string nm, int dd, int ed, int md, int wd,
                     int et, int mt, int fr, int ft, int sr);
      exp_t e;
      e.nm = nm; e.dd = dd; e.ed = ed; e.md = md; e.wd = wd;
      e.et = et; e.mt = mt; e.fr = fr; e.ft = ft; e.sr = sr;
      q_exp.push_back(e);
   endtask

   task automatic cmp(string nm, string f, int got, int want);
      if (want >= 0) begin
         n_tot++;
         if (got == want) n_pass++;
         else $display("FAIL %s.%s got=%0d expected=%0d",
                       nm, f, got, want);
      end
   endtask

   task automatic check(exp_t e);
      cmp(e.nm, "d_dst", int'(d_dst), e.dd);
      cmp(e.nm, "e_dst", int'(e_dst), e.ed);
      cmp(e.nm, "m_dst", int'(m_dst), e.md);
      cmp(e.nm, "w_dst", int'(w_dst), e.wd);
      cmp(e.nm, "e_tnew", int'(e_tnew), e.et);
      cmp(e.nm, "m_tnew", int'(m_tnew), e.mt);
      cmp(e.nm, "fwd_rs", int'(fwd_rs), e.fr);
      cmp(e.nm, "fwd_rt", int'(fwd_rt), e.ft);
      cmp(e.nm, "stall_req", int'(stall_req), e.sr);
   endtask

   initial begin
      forever begin
         @(negedge clk or mon_now);
         while (q_exp.size() != 0) check(q_exp.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(logic v, logic [1:0] sel, logic [4:0] rt,
                      logic [4:0] rd, logic [1:0] tn);
      d_valid = v; d_sel = sel; d_rt = rt; d_rd = rd; d_tnew = tn;
   endtask

   task automatic src(logic [4:0] a, logic [1:0] ta,
                      logic [4:0] b, logic [1:0] tb);
      q_rs = a; tuse_rs = ta; q_rt = b; tuse_rt = tb;
   endtask

   task automatic ctl(logic s, logic f);
      stall = s; flush_e = f;
   endtask

   initial begin
      int k;
      reset = 1'b0;
      ctl(0, 0);
      drv(0, 2'b11, 0, 0, 0);
      src(0, 0, 0, 0);
      step();
      ex("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b1;
      // destination select
      drv(1, 2'b00, 9, 12, 0);
      ex("sel_rt", 9, -1, -1, -1, -1, -1, -1, -1, -1);
      step(); drv(1, 2'b01, 9, 12, 0);
      ex("sel_rd", 12, 9, -1, -1, -1, -1, -1, -1, -1);
      step(); drv(1, 2'b10, 9, 12, 0);
      ex("sel_link", 31, 12, 9, -1, -1, -1, -1, -1, -1);
      step(); drv(1, 2'b11, 9, 12, 0);
      ex("sel_none", 0, 31, 12, 9, -1, -1, -1, -1, -1);
      step(); drv(0, 2'b00, 9, 12, 0);
      ex("sel_inval", 0, 0, 31, 12, -1, -1, -1, -1, -1);
      step(); step();
      ex("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use
      step(); drv(1, 2'b00, 8, 0, 2);
      ex("lu_d", 8, -1, -1, -1, -1, -1, -1, -1, -1);
      step(); drv(1, 2'b01, 0, 10, 1); src(8, 1, 0, 0); ctl(1, 0);
      ex("lu_stall", -1, 8, -1, -1, 2, -1, 0, -1, 1);
      step(); ctl(0, 0);
      ex("lu_m", -1, 0, 8, -1, 0, 1, 0, -1, 0);
      step(); drv(0, 2'b11, 0, 0, 0);
      ex("lu_w", -1, 10, 0, 8, 1, 0, 3, -1, 0);
      // ALU forward
      step(); src(0, 0, 0, 0); drv(1, 2'b01, 0, 5, 1);
      ex("alu_d", 5, -1, -1, -1, -1, -1, -1, -1, -1);
      step(); drv(1, 2'b11, 0, 0, 0); src(0, 0, 5, 0); ctl(1, 0);
      ex("alu_stall", -1, 5, -1, -1, 1, -1, -1, 0, 1);
      step(); ctl(0, 0);
      ex("alu_fwd", -1, 0, 5, -1, 0, 0, -1, 2, 0);
      step(); drv(1, 2'b00, 7, 0, 0);
      ex("alu_w", -1, -1, -1, 5, -1, -1, -1, 3, 0);
      // priority and $0
      step(); src(7, 0, 0, 0);
      ex("pri_e", -1, 7, -1, -1, 0, -1, 1, 0, 0);
      step(); drv(1, 2'b00, 0, 0, 2);
      ex("pri_em", -1, 7, 7, -1, 0, 0, 1, -1, 0);
      step(); src(0, 0, 0, 0); drv(1, 2'b01, 0, 3, 3);
      ex("zero", 3, 0, 7, 7, 2, 0, 0, 0, 0);
      // stall + flush together
      step(); drv(1, 2'b00, 4, 0, 1); ctl(1, 1);
      ex("sf_pre", 4, 3, 0, 7, 3, 1, 0, 0, 0);
      step(); ctl(0, 0); drv(0, 2'b11, 0, 0, 0);
      ex("sf_bubble", 0, 0, 3, 0, 0, 2, 0, 0, 0);
      step(); drv(1, 2'b00, 8, 0, 2);
      ex("sf_w", 8, 0, 0, 3, 0, 0, 0, 0, 0);
      // asynchronous reset mid-pipeline
      step(); src(8, 0, 0, 0);
      ex("pre_rst", -1, 8, 0, 0, 2, 0, 0, -1, 1);
      @(negedge clk);
      #2;
      drv(0, 2'b11, 0, 0, 0);
      reset = 1'b0;
      #1;
      ex("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      -> mon_now;
      step();
      reset = 1'b1;
      src(0, 0, 0, 0);
      ex("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      k = 0;
      while (q_exp.size() != 0 && k < 5) begin
         @(negedge clk);
         k++;
      end
      n_tot++;
      if (q_exp.size() == 0) n_pass++;
      else $display("FAIL drain_q got=%0d expected=0", q_exp.size());
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
